// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, colour codes and writer FSM encoding.
// Used by the paint writer and the scan-out side so both agree on the layout.
package fb_pkg;

  localparam logic [15:0] FB_BASE       = 16'd16384;
  localparam logic [15:0] FB_STRIDE     = 16'd16;
  localparam logic [15:0] WORDS_PER_ROW = 16'd20;
  localparam int          NUM_WORDS     = 1000;
  localparam logic [8:0]  DRAW_TOP      = 9'd80;
  localparam logic [9:0]  X_LIMIT       = 10'd640;
  localparam logic [8:0]  Y_LIMIT       = 9'd480;

  localparam logic [9:0]  TB_RED_MAX    = 10'd213;
  localparam logic [9:0]  TB_GREEN_MAX  = 10'd426;

  localparam logic [3:0]  WHITE = 4'b0000;
  localparam logic [3:0]  RED   = 4'b0001;
  localparam logic [3:0]  GREEN = 4'b0010;
  localparam logic [3:0]  BLUE  = 4'b0100;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    CLR
  } state_t;

  // Replace one 4-bit pixel of a memory word, keeping the other three.
  function automatic logic [15:0] merge_nibble(input logic [15:0] word,
                                               input logic [1:0]  n,
                                               input logic [3:0]  val);
    logic [15:0] r;
    r = word;
    r[{n, 2'b00} +: 4] = val;
    return r;
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Cursor (x, y) to frame-buffer word address / pixel nibble, plus region flags.
// Purely combinational; the draw-area row offset is only meaningful when in_draw_o.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [9:0]  x_i,
  input  logic [8:0]  y_i,
  output logic [15:0] addr_o,
  output logic [1:0]  nibble_o,
  output logic        in_draw_o,
  output logic        in_toolbar_o
);

  logic [8:0]  ydraw;
  logic [15:0] line;
  logic        in_range;

  always_comb begin
    ydraw        = y_i - DRAW_TOP;
    line         = 16'(x_i >> 5) + 16'(ydraw >> 3) * WORDS_PER_ROW;
    addr_o       = FB_BASE + line * FB_STRIDE;
    nibble_o     = 2'(x_i >> 3);
    in_range     = (x_i < X_LIMIT) && (y_i < Y_LIMIT);
    in_draw_o    = in_range && (y_i >= DRAW_TOP);
    in_toolbar_o = in_range && (y_i < DRAW_TOP);
  end

endmodule

// File: rtl/paint_writer.sv
// Paint program front end: turns cursor/button activity into read-modify-write
// pixel updates and full-canvas clears on a shared req/gnt frame-buffer port.
module paint_writer
  import fb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        clear,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [3:0]  color,
  output logic        busy
);

  state_t      state_q, state_d;
  logic [3:0]  color_q, color_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  nib_q, nib_d;
  logic [3:0]  val_q, val_d;
  logic [15:0] wdata_q, wdata_d;
  logic [9:0]  k_q, k_d;
  logic        clr_pend_q, clr_pend_d;
  logic        clr_prev_q, btn_prev_q;
  logic        last_vld_q, last_vld_d;
  logic [15:0] last_addr_q, last_addr_d;
  logic [1:0]  last_nib_q, last_nib_d;
  logic [3:0]  last_val_q, last_val_d;

  logic [15:0] c_addr;
  logic [1:0]  c_nib;
  logic        c_draw, c_tool;
  logic        clr_edge, same_cell, erase_dup, paint_dup;

  fb_addr_calc u_addr (
    .x_i          (x),
    .y_i          (y),
    .addr_o       (c_addr),
    .nibble_o     (c_nib),
    .in_draw_o    (c_draw),
    .in_toolbar_o (c_tool)
  );

  assign clr_edge  = clear & ~clr_prev_q;
  assign same_cell = last_vld_q && (last_addr_q == c_addr) && (last_nib_q == c_nib);
  assign erase_dup = same_cell && (last_val_q == WHITE);
  assign paint_dup = same_cell && (last_val_q == color_q);

  always_comb begin
    state_d     = state_q;
    color_d     = color_q;
    addr_d      = addr_q;
    nib_d       = nib_q;
    val_d       = val_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    last_vld_d  = last_vld_q;
    last_addr_d = last_addr_q;
    last_nib_d  = last_nib_q;
    last_val_d  = last_val_q;
    // A clear edge arriving while already clearing is swallowed.
    clr_pend_d  = clr_pend_q | (clr_edge & (state_q != CLR));
    case (state_q)
      IDLE: begin
        if (clr_pend_q || clr_edge) begin
          state_d    = CLR;
          k_d        = '0;
          clr_pend_d = 1'b0;
        end else if (c_draw && btn_right) begin
          if (!erase_dup) begin
            state_d = RD_REQ;
            addr_d  = c_addr;
            nib_d   = c_nib;
            val_d   = WHITE;
          end
        end else if (c_draw && btn_left) begin
          if (!paint_dup) begin
            state_d = RD_REQ;
            addr_d  = c_addr;
            nib_d   = c_nib;
            val_d   = color_q;
          end
        end else if (c_tool && btn_left && !btn_prev_q) begin
          if (x <= TB_RED_MAX)        color_d = RED;
          else if (x <= TB_GREEN_MAX) color_d = GREEN;
          else                        color_d = BLUE;
        end
      end
      RD_REQ: begin
        if (mem_gnt) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        wdata_d = merge_nibble(mem_rdata, nib_q, val_q);
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (mem_gnt) begin
          state_d     = IDLE;
          last_vld_d  = 1'b1;
          last_addr_d = addr_q;
          last_nib_d  = nib_q;
          last_val_d  = val_q;
        end
      end
      CLR: begin
        if (mem_gnt) begin
          if (k_q == 10'(NUM_WORDS - 1)) begin
            state_d    = IDLE;
            last_vld_d = 1'b0;
          end else begin
            k_d = k_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      color_q     <= RED;
      addr_q      <= '0;
      nib_q       <= '0;
      val_q       <= '0;
      wdata_q     <= '0;
      k_q         <= '0;
      clr_pend_q  <= 1'b0;
      clr_prev_q  <= 1'b0;
      btn_prev_q  <= 1'b0;
      last_vld_q  <= 1'b0;
      last_addr_q <= '0;
      last_nib_q  <= '0;
      last_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      color_q     <= color_d;
      addr_q      <= addr_d;
      nib_q       <= nib_d;
      val_q       <= val_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      clr_pend_q  <= clr_pend_d;
      clr_prev_q  <= clear;
      btn_prev_q  <= btn_left;
      last_vld_q  <= last_vld_d;
      last_addr_q <= last_addr_d;
      last_nib_q  <= last_nib_d;
      last_val_q  <= last_val_d;
    end
  end

  assign mem_req   = (state_q == RD_REQ) || (state_q == WR_REQ) || (state_q == CLR);
  assign mem_we    = (state_q == WR_REQ) || (state_q == CLR);
  assign mem_addr  = (state_q == CLR) ? (FB_BASE + 16'(k_q) * FB_STRIDE) : addr_q;
  assign mem_wdata = (state_q == WR_REQ) ? wdata_q : 16'h0000;
  assign color     = color_q;
  assign busy      = (state_q != IDLE);

endmodule
